// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: memory geometry,
// core start address and the loader state encoding.
package inst_loader_pkg;

  localparam int INST_MEM_WIDTH = 14;
  localparam int INST_WIDTH     = 32;
  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  typedef enum logic [2:0] {
    HEADER,
    LOAD,
    CHECK,
    DONE,
    ERROR
  } loader_state_t;

  // Largest word count the instruction memory can hold (address width < 32).
  function automatic logic [31:0] max_words(input int addr_width);
    return 32'(1) << addr_width;
  endfunction

endpackage

// File: rtl/inst_loader_be_word_assembler.sv
// Big-endian byte-to-word assembler: the first byte of a group of four lands
// in the most significant position; word_done flags the completing byte.
module be_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_done
);

  logic [23:0] shift_reg;
  logic [1:0]  byte_cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg    <= '0;
      byte_cnt_reg <= '0;
    end else if (byte_en) begin
      shift_reg    <= {shift_reg[15:0], byte_data};
      byte_cnt_reg <= byte_cnt_reg + 2'd1;
    end
  end

  // The fourth byte is taken straight from the input so the word is usable
  // on the same edge that accepts it.
  assign word      = {shift_reg, byte_data};
  assign word_done = byte_en && (byte_cnt_reg == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Loads a counted, XOR-checksummed instruction image from the UART byte
// stream into instruction memory and releases the cores once it is accepted.
module inst_loader #(
  parameter int INST_MEM_WIDTH = inst_loader_pkg::INST_MEM_WIDTH,
  parameter int INST_WIDTH     = inst_loader_pkg::INST_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      rx_ready,
  output logic                      we,
  output logic [INST_MEM_WIDTH-1:0] waddr,
  output logic [INST_WIDTH-1:0]     wdata,
  output logic                      release_cores,
  output logic                      error
);

  localparam logic [31:0] MAX_WORDS = inst_loader_pkg::max_words(INST_MEM_WIDTH);

  inst_loader_pkg::loader_state_t state_reg;

  logic                      rx_ready_reg;
  logic                      we_reg;
  logic [INST_MEM_WIDTH-1:0] waddr_reg;
  logic [INST_WIDTH-1:0]     wdata_reg;
  logic                      release_reg;
  logic                      error_reg;
  logic [7:0]                csum_reg;
  logic [INST_MEM_WIDTH:0]   word_cnt_reg;
  logic [31:0]               count_reg;

  logic                      accept;
  logic                      asm_en;
  logic [31:0]               word;
  logic                      word_done;
  logic [INST_MEM_WIDTH:0]   word_cnt_next;

  assign accept        = rx_valid && rx_ready_reg;
  assign asm_en        = accept && ((state_reg == inst_loader_pkg::HEADER) ||
                                    (state_reg == inst_loader_pkg::LOAD));
  assign word_cnt_next = word_cnt_reg + 1'b1;

  be_word_assembler u_assembler (
    .clk       (clk),
    .reset     (reset),
    .byte_en   (asm_en),
    .byte_data (rx_data),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= inst_loader_pkg::HEADER;
      rx_ready_reg <= 1'b1;
      we_reg       <= 1'b0;
      waddr_reg    <= '0;
      wdata_reg    <= '0;
      release_reg  <= 1'b0;
      error_reg    <= 1'b0;
      csum_reg     <= '0;
      word_cnt_reg <= '0;
      count_reg    <= '0;
    end else begin
      we_reg <= 1'b0;
      case (state_reg)
        inst_loader_pkg::HEADER: begin
          if (word_done) begin
            count_reg    <= word;
            word_cnt_reg <= '0;
            if (word > MAX_WORDS) begin
              state_reg    <= inst_loader_pkg::ERROR;
              error_reg    <= 1'b1;
              rx_ready_reg <= 1'b0;
            end else if (word == 32'd0) begin
              state_reg <= inst_loader_pkg::CHECK;
            end else begin
              state_reg <= inst_loader_pkg::LOAD;
            end
          end
        end
        inst_loader_pkg::LOAD: begin
          if (accept) begin
            csum_reg <= csum_reg ^ rx_data;
            if (word_done) begin
              we_reg       <= 1'b1;
              waddr_reg    <= word_cnt_reg[INST_MEM_WIDTH-1:0];
              wdata_reg    <= word[INST_WIDTH-1:0];
              word_cnt_reg <= word_cnt_next;
              // Full-width compare: the count can never exceed MAX_WORDS here.
              if (32'(word_cnt_next) == count_reg) begin
                state_reg <= inst_loader_pkg::CHECK;
              end
            end
          end
        end
        inst_loader_pkg::CHECK: begin
          if (accept) begin
            rx_ready_reg <= 1'b0;
            if (rx_data == csum_reg) begin
              state_reg   <= inst_loader_pkg::DONE;
              release_reg <= 1'b1;
            end else begin
              state_reg <= inst_loader_pkg::ERROR;
              error_reg <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_ready      = rx_ready_reg;
  assign we            = we_reg;
  assign waddr         = waddr_reg;
  assign wdata         = wdata_reg;
  assign release_cores = release_reg;
  assign error         = error_reg;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with a write scoreboard: expected writes are
// queued as words are sent and matched against the observed we pulses.
module tb_inst_loader;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          release_cores;
  logic          error;

  int errors = 0;
  int checks = 0;

  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] obs_q[$];
  logic [7:0]     csum_model;
  int             addr_model;
  bit             gaps_en;

  always #5 clk = ~clk;

  inst_loader #(.INST_MEM_WIDTH(AW), .INST_WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_ready      (rx_ready),
    .we            (we),
    .waddr         (waddr),
    .wdata         (wdata),
    .release_cores (release_cores),
    .error         (error)
  );

  always @(negedge clk) begin
    if (we === 1'b1) obs_q.push_back({waddr, wdata});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    if (gaps_en) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    check("rx_ready_while_loading", rx_ready, 1'b1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit payload);
    logic [7:0] b;
    for (int i = 3; i >= 0; i--) begin
      b = w[8*i +: 8];
      if (payload) csum_model ^= b;
      send_byte(b);
    end
    if (payload) begin
      exp_q.push_back({AW'(addr_model), w});
      addr_model++;
    end
  endtask

  task automatic send_csum(input logic [7:0] b, input bit good);
    rx_valid = 1'b1;
    rx_data  = b;
    check("release_before_csum", release_cores, 1'b0);
    check("error_before_csum", error, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    $display("checksum byte 0x%02h sent: release=%0b error=%0b", b, release_cores, error);
    check("release_after_csum", release_cores, good);
    check("error_after_csum", error, !good);
    check("rx_ready_after_csum", rx_ready, 1'b0);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset      = 1'b0;
    csum_model = 8'h00;
    addr_model = 0;
    check("reset_rx_ready", rx_ready, 1'b1);
    check("reset_we", we, 1'b0);
    check("reset_waddr", 32'(waddr), 32'd0);
    check("reset_wdata", wdata, 32'd0);
    check("reset_release", release_cores, 1'b0);
    check("reset_error", error, 1'b0);
  endtask

  task automatic compare_writes(input string tag);
    logic [AW+31:0] e;
    logic [AW+31:0] o;
    check({tag, "_write_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      $display("%s write: addr=%0d data=0x%08h (expected addr=%0d data=0x%08h)",
               tag, o[AW+31:32], o[31:0], e[AW+31:32], e[31:0]);
      check({tag, "_waddr"}, 32'(o[AW+31:32]), 32'(e[AW+31:32]));
      check({tag, "_wdata"}, o[31:0], e[31:0]);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    gaps_en    = 1'b0;
    addr_model = 0;
    csum_model = 8'h00;
    do_reset();

    // Two words, correct checksum (XOR of the eight payload bytes)
    send_word(32'd2, 1'b0);
    send_word(32'h1234_5678, 1'b1);
    send_word(32'h9ABC_DEF0, 1'b1);
    send_csum(csum_model, 1'b1);
    compare_writes("n2_good");

    // Same image, corrupted checksum
    do_reset();
    send_word(32'd2, 1'b0);
    send_word(32'h1234_5678, 1'b1);
    send_word(32'h9ABC_DEF0, 1'b1);
    send_csum(csum_model ^ 8'h01, 1'b0);
    compare_writes("n2_bad");

    // Empty image
    do_reset();
    send_word(32'd0, 1'b0);
    send_csum(8'h00, 1'b1);
    compare_writes("n0");

    // One word more than the memory holds
    do_reset();
    send_word(32'd17, 1'b0);
    $display("oversize header sent: error=%0b rx_ready=%0b", error, rx_ready);
    check("oversize_error", error, 1'b1);
    check("oversize_release", release_cores, 1'b0);
    check("oversize_rx_ready", rx_ready, 1'b0);
    repeat (3) @(negedge clk);
    compare_writes("oversize");

    // Exactly full memory, random gaps on rx_valid
    do_reset();
    gaps_en = 1'b1;
    send_word(32'd16, 1'b0);
    for (int i = 0; i < 16; i++) send_word($urandom, 1'b1);
    gaps_en = 1'b0;
    send_csum(csum_model, 1'b1);
    compare_writes("n16_gaps");

    // Reset in the middle of a load, then a fresh single-word image
    do_reset();
    send_word(32'd2, 1'b0);
    send_word(32'hAABB_CCDD, 1'b1);
    send_byte(8'h11);
    send_byte(8'h22);
    compare_writes("aborted");
    do_reset();
    exp_q.push_back({AW'(0), 32'hDEAD_BEEF});
    send_word(32'd1, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    send_csum(8'h22, 1'b1);
    compare_writes("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
